// File: rtl/div_share_scheduler.sv
// div_share_scheduler: round-robin arbiter that time-shares one sequential
// unsigned divider among NUM_REQ requesters (IDLE -> ISSUE -> WAIT -> RESP).
// Optional feature macro: DIV_SHARE_ZERO_GUARD_EN (zero divisor answered
// locally with all-ones quotient and error, never sent to the divider).
module div_share_scheduler #(
    parameter int CLOUD_BW   = 8,
    parameter int H_SIZE_BW  = 8,
    parameter int V_SIZE_BW  = 8,
    parameter int NUM_REQ    = 2,
    parameter int DEND_WIDTH = 4*CLOUD_BW,
    parameter int DSOR_WIDTH = H_SIZE_BW+V_SIZE_BW,
    parameter int TIMEOUT    = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DEND_WIDTH-1:0] i_dend,
    input  logic [NUM_REQ*DSOR_WIDTH-1:0] i_dsor,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic                          o_div_valid,
    output logic [DEND_WIDTH-1:0]         o_div_dend,
    output logic [DSOR_WIDTH-1:0]         o_div_dsor,
    input  logic                          i_div_valid,
    input  logic [DEND_WIDTH-1:0]         i_div_quot,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DEND_WIDTH-1:0]         o_rsp_quot,
    output logic                          o_rsp_err,
    output logic                          o_busy
);
    localparam int CNT_W = $clog2(TIMEOUT+1);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [DEND_WIDTH-1:0] dend_q, dend_d;
    logic [DSOR_WIDTH-1:0] dsor_q, dsor_d;
    logic [DEND_WIDTH-1:0] quot_q, quot_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [DSOR_WIDTH-1:0] win_dsor;

    // Round-robin pick: first active request at or after rr_ptr.
    always_comb begin
        int c;
        c         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && i_req[c]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
        win_dsor = i_dsor[win_idx*DSOR_WIDTH +: DSOR_WIDTH];
    end

    // Next-state and output decode; grant and response are one-cycle pulses.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        dend_d      = dend_q;
        dsor_d      = dsor_q;
        quot_d      = quot_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        o_gnt       = '0;
        o_rsp_valid = '0;
        unique case (state_q)
            S_IDLE: begin
                // Gated by reset so a held request cannot leak a grant.
                if (win_found && i_rst_n) begin
                    o_gnt[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    dend_d         = i_dend[win_idx*DEND_WIDTH +: DEND_WIDTH];
                    dsor_d         = win_dsor;
                    state_d        = S_ISSUE;
`ifdef DIV_SHARE_ZERO_GUARD_EN
                    if (win_dsor == '0) begin
                        quot_d  = '1;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_div_valid) begin
                    quot_d  = i_div_quot;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    // Saturating counter; reaching TIMEOUT ends the wait.
                    if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
                    if (cnt_q >= CNT_W'(TIMEOUT-1)) begin
                        quot_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                o_rsp_valid[owner_q] = 1'b1;
                rr_ptr_d = (int'(owner_q) == NUM_REQ-1) ? '0 : owner_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            dend_q   <= '0;
            dsor_q   <= '0;
            quot_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            dend_q   <= dend_d;
            dsor_q   <= dsor_d;
            quot_q   <= quot_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_div_valid = (state_q == S_ISSUE);
    assign o_div_dend  = dend_q;
    assign o_div_dsor  = dsor_q;
    assign o_rsp_quot  = quot_q;
    assign o_rsp_err   = err_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_share_scheduler.sv
// Directed bench for div_share_scheduler: single request, contention,
// timeout (second instance with TIMEOUT=10), reset mid-WAIT, spurious
// divider result and zero divisor (with or without DIV_SHARE_ZERO_GUARD_EN).
module tb_div_share_scheduler;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [63:0] dend = '0;
    logic [31:0] dsor = '0;
    logic [1:0]  gnt, rsp_valid;
    logic        div_valid, rsp_err, busy;
    logic [31:0] div_dend, rsp_quot;
    logic [15:0] div_dsor;
    logic        d_valid = 1'b0;
    logic [31:0] d_quot = '0;

    // timeout instance signals
    logic [1:0]  t_req = '0;
    logic [63:0] t_dend = {32'd0, 32'd50};
    logic [31:0] t_dsor = {16'd0, 16'd5};
    logic [1:0]  t_gnt, t_rsp_valid;
    logic        t_div_valid, t_rsp_err, t_busy;
    logic [31:0] t_div_dend, t_rsp_quot;
    logic [15:0] t_div_dsor;
    logic        t_d_valid = 1'b0;
    logic [31:0] t_d_quot = '0;

    int n_asrt = 0;
    int n_fail = 0;
    int dv_cnt = 0;
    int rsp_cnt = 0;
    int gnt_cnt = 0;

    always #5 i_clk = ~i_clk;

    div_share_scheduler dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(req), .i_dend(dend), .i_dsor(dsor),
        .o_gnt(gnt), .o_div_valid(div_valid), .o_div_dend(div_dend), .o_div_dsor(div_dsor),
        .i_div_valid(d_valid), .i_div_quot(d_quot), .o_rsp_valid(rsp_valid),
        .o_rsp_quot(rsp_quot), .o_rsp_err(rsp_err), .o_busy(busy)
    );

    div_share_scheduler #(.TIMEOUT(10)) dut_to (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(t_req), .i_dend(t_dend), .i_dsor(t_dsor),
        .o_gnt(t_gnt), .o_div_valid(t_div_valid), .o_div_dend(t_div_dend), .o_div_dsor(t_div_dsor),
        .i_div_valid(t_d_valid), .i_div_quot(t_d_quot), .o_rsp_valid(t_rsp_valid),
        .o_rsp_quot(t_rsp_quot), .o_rsp_err(t_rsp_err), .o_busy(t_busy)
    );

    // Pulse counters on the main instance, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (div_valid) dv_cnt++;
        if (rsp_valid != 2'b00) rsp_cnt++;
        if (gnt != 2'b00) gnt_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_rst_n = 1'b0;
        #3;
        i_rst_n = 1'b1;
        #0;
    endtask

    initial begin
        int n;
        int dv0;
        int rc0;
        logic [1:0] exp_g;

        // ---- reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_dend", div_dend, 0);
        chk("rst_divv", div_valid, 0);
        step;
        i_rst_n = 1'b1;

        // ---- single request: 100/7, divider answers 14 after 20 cycles
        step;
        req = 2'b01; dend = {32'd0, 32'd100}; dsor = {16'd0, 16'd7};
        #1;
        chk("single_gnt", gnt, 2'b01);
        step;
        req = 2'b00;
        chk("single_divv", div_valid, 1);
        chk("single_dend", div_dend, 100);
        chk("single_dsor", div_dsor, 7);
        chk("single_busy", busy, 1);
        for (int i = 0; i < 19; i++) step;
        d_valid = 1'b1; d_quot = 32'd14;
        step;
        d_valid = 1'b0;
        chk("single_rspv", rsp_valid, 2'b01);
        chk("single_quot", rsp_quot, 14);
        chk("single_err", rsp_err, 0);
        step;
        chk("single_idle", busy, 0);
        chk("single_hold_dend", div_dend, 100);
        chk("single_gnt_cnt", gnt_cnt, 1);
        chk("single_dv_cnt", dv_cnt, 1);
        chk("single_rsp_cnt", rsp_cnt, 1);

        // ---- contention: both held, expect 0,1,0,1
        do_reset;
        dend = {32'd200, 32'd100}; dsor = {16'd3, 16'd7};
        req = 2'b11;
        dv0 = dv_cnt;
        #1;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (gnt == 2'b00 && n < 20) begin step; n++; end
            chk("cont_gnt", gnt, exp_g);
            step;
            chk("cont_busy_nognt", gnt, 0);
            chk("cont_dend", div_dend, (t % 2 == 0) ? 100 : 200);
            step;
            d_valid = 1'b1; d_quot = 32'(t + 1);
            step;
            d_valid = 1'b0;
            chk("cont_rspv", rsp_valid, exp_g);
            chk("cont_quot", rsp_quot, t + 1);
            chk("cont_rsp_nognt", gnt, 0);
            step;
        end
        req = 2'b00;
        chk("cont_dv_cnt", dv_cnt - dv0, 4);

        // ---- timeout on TIMEOUT=10 instance: response 11 cycles after div_valid
        t_req = 2'b01;
        step;
        t_req = 2'b00;
        chk("to_divv", t_div_valid, 1);
        n = 0;
        while (t_rsp_valid == 2'b00 && n < 50) begin step; n++; end
        chk("to_latency", n, 11);
        chk("to_rspv", t_rsp_valid, 2'b01);
        chk("to_err", t_rsp_err, 1);
        chk("to_quot", t_rsp_quot, 0);
        step;
        chk("to_idle", t_busy, 0);

        // ---- reset mid-WAIT, late divider result ignored
        req = 2'b01; dend = {32'd0, 32'd77}; dsor = {16'd0, 16'd7};
        step;
        req = 2'b00;
        step;
        step;
        chk("rstw_busy_pre", busy, 1);
        i_rst_n = 1'b0;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_dend", div_dend, 0);
        step;
        i_rst_n = 1'b1;
        rc0 = rsp_cnt;
        d_valid = 1'b1; d_quot = 32'd5;
        step;
        d_valid = 1'b0;
        chk("rstw_norsp", rsp_valid, 0);
        step;
        chk("rstw_busy_post", busy, 0);
        chk("rstw_rsp_cnt", rsp_cnt - rc0, 0);

        // ---- spurious divider result in IDLE
        d_valid = 1'b1; d_quot = 32'd9;
        step;
        d_valid = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_rsp", rsp_valid, 0);
        step;
        chk("spur_rsp_cnt", rsp_cnt - rc0, 0);

        // ---- zero divisor
        dv0 = dv_cnt;
        req = 2'b01; dend = {32'd0, 32'd33}; dsor = 32'd0;
        #1;
        chk("zero_gnt", gnt, 2'b01);
        step;
        req = 2'b00;
`ifdef DIV_SHARE_ZERO_GUARD_EN
        chk("zero_nodivv", div_valid, 0);
        chk("zero_rspv", rsp_valid, 2'b01);
        chk("zero_quot", rsp_quot, 32'hFFFF_FFFF);
        chk("zero_err", rsp_err, 1);
        step;
        chk("zero_dv_cnt", dv_cnt - dv0, 0);
`else
        chk("zero_divv", div_valid, 1);
        step;
        d_valid = 1'b1; d_quot = 32'd0;
        step;
        d_valid = 1'b0;
        chk("zero_rspv", rsp_valid, 2'b01);
        chk("zero_err", rsp_err, 0);
        step;
        chk("zero_dv_cnt", dv_cnt - dv0, 1);
`endif
        chk("zero_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/div_share_scheduler.md
DIV_SHARE_SCHEDULER -- requirements
Module: div_share_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters sharing one sequential unsigned divider (2..4).
REQ-002 SHALL have parameter DEND_WIDTH, default 4*CLOUD_BW: dividend width.
REQ-003 SHALL have parameter DSOR_WIDTH, default H_SIZE_BW+V_SIZE_BW: divisor width.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for a divider result.
REQ-005 SHALL have port i_clk  in  1  the single clock; all logic is rising-edge.
REQ-006 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_req  in  NUM_REQ  per-requester level request, held until granted.
REQ-008 SHALL have port i_dend  in  NUM_REQ*DEND_WIDTH  packed dividends; requester k occupies slice k.
REQ-009 SHALL have port i_dsor  in  NUM_REQ*DSOR_WIDTH  packed divisors; requester k occupies slice k.
REQ-010 SHALL have port o_gnt  out  NUM_REQ  one-hot, one-cycle grant pulse; operands are latched on that cycle.
REQ-011 SHALL have ports o_div_valid/o_div_dend/o_div_dsor  out  1/DEND_WIDTH/DSOR_WIDTH  issue to the divider.
REQ-012 SHALL have ports i_div_valid/i_div_quot  in  1/DEND_WIDTH  divider completion pulse and quotient.
REQ-013 SHALL have ports o_rsp_valid/o_rsp_quot/o_rsp_err  out  NUM_REQ/DEND_WIDTH/1  one-hot response pulse, quotient, error flag.
REQ-014 SHALL have port o_busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if any i_req is high, SHALL select a winner by round-robin starting from rr_ptr, pulse o_gnt[winner], latch its operands and owner index, and go to ISSUE in the same cycle.
REQ-017 ISSUE: SHALL drive o_div_valid=1 for exactly one cycle with the latched operands, clear the timeout counter, and go to WAIT.
REQ-018 WAIT: on i_div_valid SHALL latch i_div_quot and go to RESP with err=0; otherwise SHALL increment the counter and, when it reaches TIMEOUT, go to RESP with err=1 and quotient 0.
REQ-019 RESP: SHALL pulse o_rsp_valid[owner] for one cycle with o_rsp_quot/o_rsp_err held valid, set rr_ptr=(owner+1) mod NUM_REQ, and return to IDLE.
REQ-020 i_div_valid outside WAIT SHALL be ignored.
REQ-021 A request arriving during a busy state SHALL wait; no grant is issued before the cycle after RESP (minimum 4 cycles between grants).
REQ-022 o_div_dend/o_div_dsor SHALL hold the latched operands from grant until the next grant.
REQ-023 A deasserted i_req before grant SHALL simply drop that request from the candidate set.
REQ-024 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-025 On i_rst_n low, SHALL immediately force state=IDLE, rr_ptr=0, and all outputs to 0, including mid-WAIT; a divider result arriving after reset release SHALL be ignored.

Configuration
REQ-026 With macro DIV_SHARE_ZERO_GUARD_EN defined, a winner whose divisor is 0 SHALL still be granted, but SHALL skip ISSUE/WAIT and go directly to RESP with quotient all ones and err=1; without the macro, a zero divisor SHALL be issued like any other.

Verification
REQ-027 Single request: req[0] with dend=100 and dsor=7; divider returns 14 after 20 cycles -> gnt[0] once, one div_valid, rsp_valid[0] with quot=14 and err=0.
REQ-028 Contention: req[0] and req[1] held together after reset -> grant order 0,1,0,1 over four transactions; no overlapping div_valid.
REQ-029 Timeout: TIMEOUT=10, divider never responds -> rsp_valid with err=1 and quot=0, exactly 11 cycles after div_valid.
REQ-030 Reset mid-WAIT: assert i_rst_n low, then inject i_div_valid after release -> no rsp_valid; o_busy=0.
REQ-031 Zero divisor with the macro defined: dsor=0 -> no div_valid, rsp quot=all ones with err=1; without the macro -> div_valid issued.
REQ-032 Spurious i_div_valid in IDLE -> no response and no state change.
